pc_stack_unit: RTL and testbench

Parametrised program-counter and return-address-stack unit for the 4-bit CPU family. Generalises the fixed 12-bit PC and 3-level stack to configurable address width, stack depth and overflow mode. Adds explicit occupancy tracking, sticky overflow/underflow flags, page-relative jumps and skip. Advances once per instruction cycle, on a strobe from the cycle sequencer.

---
 rtl/pc_stack_unit.sv | 148 ++++++++++++++
 tb/tb_pc_stack_unit.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_stack_unit.sv
// Program counter and return-address stack for the 4-bit CPU family.
// Advances once per instruction cycle, when the sequencer asserts step.
// The stack depth, the address width and the overflow/underflow policy are parameters.
//
// Ports:
//   cp2       in   clock; all state updates on the rising edge
//   reset     in   synchronous, active-high reset
//   step      in   instruction-cycle strobe; op and target are used only when it is high
//   op        in   0 HOLD, 1 INC, 2 JUMP, 3 JPAGE, 4 CALL, 5 RET, 6 SKIP, 7 INC
//   target    in   jump/call address; JPAGE uses only the low PAGE_W bits
//   clr_err   in   clears ovf/unf, independent of step
//   pc        out  current program counter
//   stack_top out  entry 0 (next return address); 0 when the stack is empty
//   level     out  number of occupied entries, 0..DEPTH
//   full      out  level == DEPTH
//   empty     out  level == 0
//   ovf       out  sticky: a CALL hit a full stack
//   unf       out  sticky: a RET hit an empty stack
module pc_stack_unit #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned PAGE_W = 8,
    parameter int unsigned DEPTH  = 3,
    parameter int unsigned WRAP   = 1
) (
    input  logic                         cp2,
    input  logic                         reset,
    input  logic                         step,
    input  logic [2:0]                   op,
    input  logic [ADDR_W-1:0]            target,
    input  logic                         clr_err,
    output logic [ADDR_W-1:0]            pc,
    output logic [ADDR_W-1:0]            stack_top,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         full,
    output logic                         empty,
    output logic                         ovf,
    output logic                         unf
);

    localparam int unsigned LVL_W   = $clog2(DEPTH + 1);
    localparam bit          WRAP_EN = (WRAP != 0);

    localparam logic [2:0] OP_HOLD  = 3'd0;
    localparam logic [2:0] OP_INC   = 3'd1;
    localparam logic [2:0] OP_JUMP  = 3'd2;
    localparam logic [2:0] OP_JPAGE = 3'd3;
    localparam logic [2:0] OP_CALL  = 3'd4;
    localparam logic [2:0] OP_RET   = 3'd5;
    localparam logic [2:0] OP_SKIP  = 3'd6;
    localparam logic [2:0] OP_INC2  = 3'd7;

    logic [ADDR_W-1:0] stk_q   [DEPTH];
    logic [ADDR_W-1:0] stk_nxt [DEPTH];
    logic [ADDR_W-1:0] pc_nxt;
    logic [ADDR_W-1:0] pc_inc;
    logic [LVL_W-1:0]  level_nxt;
    logic              ovf_nxt;
    logic              unf_nxt;

    assign pc_inc    = pc + ADDR_W'(1);
    // Unoccupied entries are always 0, so entry 0 already reads 0 when the stack is empty.
    assign stack_top = stk_q[0];

    // Next-state decode for one instruction cycle.
    always_comb begin
        pc_nxt    = pc;
        stk_nxt   = stk_q;
        level_nxt = level;
        ovf_nxt   = ovf;
        unf_nxt   = unf;

        // Clear first so that a flag set on the same edge overrides the clear.
        if (clr_err) begin
            ovf_nxt = 1'b0;
            unf_nxt = 1'b0;
        end

        if (step) begin
            case (op)
                OP_HOLD:  pc_nxt = pc;
                OP_INC,
                OP_INC2:  pc_nxt = pc_inc;
                OP_SKIP:  pc_nxt = pc + ADDR_W'(2);
                OP_JUMP:  pc_nxt = target;
                OP_JPAGE: pc_nxt = {pc[ADDR_W-1:PAGE_W], target[PAGE_W-1:0]};
                OP_CALL: begin
                    if (!full || WRAP_EN) begin
                        // Push: the deepest entry falls off when the stack is already full.
                        for (int i = DEPTH - 1; i > 0; i--) begin
                            stk_nxt[i] = stk_q[i-1];
                        end
                        stk_nxt[0] = pc_inc;
                        pc_nxt     = target;
                        if (!full) begin
                            level_nxt = level + LVL_W'(1);
                        end
                    end else begin
                        pc_nxt = pc_inc;
                    end
                    if (full) begin
                        ovf_nxt = 1'b1;
                    end
                end
                OP_RET: begin
                    if (!empty || WRAP_EN) begin
                        // Pop: on an empty stack entry 0 is 0, so the PC goes to 0.
                        pc_nxt = stk_q[0];
                        for (int i = 0; i < DEPTH - 1; i++) begin
                            stk_nxt[i] = stk_q[i+1];
                        end
                        stk_nxt[DEPTH-1] = '0;
                        if (!empty) begin
                            level_nxt = level - LVL_W'(1);
                        end
                    end else begin
                        pc_nxt = pc_inc;
                    end
                    if (empty) begin
                        unf_nxt = 1'b1;
                    end
                end
                default:  pc_nxt = pc;
            endcase
        end
    end

    // State registers; full/empty are registered from the next level.
    always_ff @(posedge cp2) begin
        if (reset) begin
            pc    <= '0;
            stk_q <= '{default: '0};
            level <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            pc    <= pc_nxt;
            stk_q <= stk_nxt;
            level <= level_nxt;
            full  <= (level_nxt == LVL_W'(DEPTH));
            empty <= (level_nxt == '0);
            ovf   <= ovf_nxt;
            unf   <= unf_nxt;
        end
    end

endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed bench for pc_stack_unit: instance 0 is built with WRAP=1 and instance 1 with WRAP=0.
// The driver queues a hand-computed expected state for each edge.
// A separate monitor compares that state against the DUT on the next falling edge.
module tb_pc_stack_unit;

    localparam logic [2:0] HOLD = 3'd0, INC = 3'd1, JUMP = 3'd2, JPAGE = 3'd3,
                           CALL = 3'd4, RET = 3'd5, SKIP = 3'd6, INC7 = 3'd7;

    typedef struct {
        int          cyc;
        int          d;
        logic [29:0] v;
        string       nm;
    } exp_t;

    logic        cp2 = 1'b0;
    logic        rst_v  [2];
    logic        step_v [2];
    logic [2:0]  op_v   [2];
    logic [11:0] tgt_v  [2];
    logic        clr_v  [2];

    logic [11:0] pc_o  [2];
    logic [11:0] top_o [2];
    logic [1:0]  lvl_o [2];
    logic        full_o[2], empty_o[2], ovf_o[2], unf_o[2];
    logic [29:0] obs   [2];

    exp_t exp_q[$];
    int   cyc_cnt  = 0;
    int   checks   = 0;
    int   failures = 0;

    always #5 cp2 = ~cp2;
    always @(posedge cp2) cyc_cnt <= cyc_cnt + 1;

    pc_stack_unit #(.ADDR_W(12), .PAGE_W(8), .DEPTH(3), .WRAP(1)) u_wrap (
        .cp2(cp2), .reset(rst_v[0]), .step(step_v[0]), .op(op_v[0]), .target(tgt_v[0]),
        .clr_err(clr_v[0]), .pc(pc_o[0]), .stack_top(top_o[0]), .level(lvl_o[0]),
        .full(full_o[0]), .empty(empty_o[0]), .ovf(ovf_o[0]), .unf(unf_o[0])
    );

    pc_stack_unit #(.ADDR_W(12), .PAGE_W(8), .DEPTH(3), .WRAP(0)) u_refuse (
        .cp2(cp2), .reset(rst_v[1]), .step(step_v[1]), .op(op_v[1]), .target(tgt_v[1]),
        .clr_err(clr_v[1]), .pc(pc_o[1]), .stack_top(top_o[1]), .level(lvl_o[1]),
        .full(full_o[1]), .empty(empty_o[1]), .ovf(ovf_o[1]), .unf(unf_o[1])
    );

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            obs[k] = {pc_o[k], top_o[k], lvl_o[k], full_o[k], empty_o[k], ovf_o[k], unf_o[k]};
        end
    end

    // Monitor: compare every expectation due on this cycle; a stale entry is a miss.
    always @(negedge cp2) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc_cnt) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (e.cyc < cyc_cnt) begin
                failures++;
                $display("FAIL %s dut%0d: expectation for cycle %0d not checked (now %0d)",
                         e.nm, e.d, e.cyc, cyc_cnt);
            end else if (obs[e.d] !== e.v) begin
                failures++;
                $display("FAIL %s dut%0d: got pc=%h top=%h lvl=%0d f=%b e=%b o=%b u=%b, want pc=%h top=%h lvl=%0d f=%b e=%b o=%b u=%b",
                         e.nm, e.d, obs[e.d][29:18], obs[e.d][17:6], obs[e.d][5:4], obs[e.d][3],
                         obs[e.d][2], obs[e.d][1], obs[e.d][0], e.v[29:18], e.v[17:6], e.v[5:4],
                         e.v[3], e.v[2], e.v[1], e.v[0]);
            end
        end
    end

    function automatic logic [29:0] pack(input logic [11:0] p, input logic [11:0] t,
                                         input logic [1:0] l, input logic o, input logic u);
        return {p, t, l, (l == 2'd3), (l == 2'd0), o, u};
    endfunction

    task automatic idle_all();
        for (int k = 0; k < 2; k++) begin
            rst_v[k]  = 1'b0;
            step_v[k] = 1'b0;
            op_v[k]   = HOLD;
            tgt_v[k]  = 12'h000;
            clr_v[k]  = 1'b0;
        end
    endtask

    // Drive one edge on DUT d (the other stays idle) and queue its expected state.
    task automatic drv(input int d, input logic st, input logic [2:0] o, input logic [11:0] t,
                       input logic c, input logic [11:0] epc, input logic [11:0] etop,
                       input logic [1:0] el, input logic eo, input logic eu, input string nm);
        exp_t e;
        idle_all();
        step_v[d] = st;
        op_v[d]   = o;
        tgt_v[d]  = t;
        clr_v[d]  = c;
        e.cyc = cyc_cnt + 1;
        e.d   = d;
        e.v   = pack(epc, etop, el, eo, eu);
        e.nm  = nm;
        exp_q.push_back(e);
        @(posedge cp2);
        #1;
    endtask

    // Reset both DUTs, with an op pending to show reset takes priority.
    task automatic rst_all(input string nm);
        exp_t e;
        idle_all();
        for (int k = 0; k < 2; k++) begin
            rst_v[k]  = 1'b1;
            step_v[k] = 1'b1;
            op_v[k]   = CALL;
            tgt_v[k]  = 12'hFFF;
            e.cyc = cyc_cnt + 1;
            e.d   = k;
            e.v   = pack(12'h000, 12'h000, 2'd0, 1'b0, 1'b0);
            e.nm  = nm;
            exp_q.push_back(e);
        end
        @(posedge cp2);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_all();
        rst_all("reset");

        // 1: increment, then reset
        drv(0, 1, INC,  12'h000, 0, 12'h001, 12'h000, 0, 0, 0, "inc1");
        drv(0, 1, INC,  12'h000, 0, 12'h002, 12'h000, 0, 0, 0, "inc2");
        drv(0, 1, INC,  12'h000, 0, 12'h003, 12'h000, 0, 0, 0, "inc3");
        drv(0, 1, INC,  12'h000, 0, 12'h004, 12'h000, 0, 0, 0, "inc4");
        drv(0, 1, INC,  12'h000, 0, 12'h005, 12'h000, 0, 0, 0, "inc5");
        rst_all("reset_again");

        // 2: nested calls and returns
        drv(0, 1, JUMP, 12'h010, 0, 12'h010, 12'h000, 0, 0, 0, "jump010");
        drv(0, 1, CALL, 12'h100, 0, 12'h100, 12'h011, 1, 0, 0, "call100");
        drv(0, 1, CALL, 12'h200, 0, 12'h200, 12'h101, 2, 0, 0, "call200");
        drv(0, 1, CALL, 12'h300, 0, 12'h300, 12'h201, 3, 0, 0, "call300");
        drv(0, 1, RET,  12'h000, 0, 12'h201, 12'h101, 2, 0, 0, "ret1");
        drv(0, 1, RET,  12'h000, 0, 12'h101, 12'h011, 1, 0, 0, "ret2");
        drv(0, 1, RET,  12'h000, 0, 12'h011, 12'h000, 0, 0, 0, "ret3");

        // 3: overflow and underflow in WRAP mode
        drv(0, 1, JUMP, 12'h010, 0, 12'h010, 12'h000, 0, 0, 0, "w_jump");
        drv(0, 1, CALL, 12'h100, 0, 12'h100, 12'h011, 1, 0, 0, "w_call1");
        drv(0, 1, CALL, 12'h200, 0, 12'h200, 12'h101, 2, 0, 0, "w_call2");
        drv(0, 1, CALL, 12'h300, 0, 12'h300, 12'h201, 3, 0, 0, "w_call3");
        drv(0, 1, CALL, 12'hABC, 0, 12'hABC, 12'h301, 3, 1, 0, "w_ovf_call");
        drv(0, 1, RET,  12'h000, 0, 12'h301, 12'h201, 2, 1, 0, "w_ret1");
        drv(0, 1, RET,  12'h000, 0, 12'h201, 12'h101, 1, 1, 0, "w_ret2");
        drv(0, 1, RET,  12'h000, 0, 12'h101, 12'h000, 0, 1, 0, "w_ret3");
        drv(0, 1, RET,  12'h000, 0, 12'h000, 12'h000, 0, 1, 1, "w_unf_ret");
        drv(0, 1, HOLD, 12'h000, 1, 12'h000, 12'h000, 0, 0, 0, "w_clr");

        // 4: overflow and underflow in refuse mode
        drv(1, 1, JUMP, 12'h010, 0, 12'h010, 12'h000, 0, 0, 0, "r_jump");
        drv(1, 1, CALL, 12'h100, 0, 12'h100, 12'h011, 1, 0, 0, "r_call1");
        drv(1, 1, CALL, 12'h200, 0, 12'h200, 12'h101, 2, 0, 0, "r_call2");
        drv(1, 1, CALL, 12'h300, 0, 12'h300, 12'h201, 3, 0, 0, "r_call3");
        drv(1, 1, CALL, 12'h555, 0, 12'h301, 12'h201, 3, 1, 0, "r_ovf_call");
        drv(1, 1, RET,  12'h000, 0, 12'h201, 12'h101, 2, 1, 0, "r_ret1");
        drv(1, 1, RET,  12'h000, 0, 12'h101, 12'h011, 1, 1, 0, "r_ret2");
        drv(1, 1, RET,  12'h000, 0, 12'h011, 12'h000, 0, 1, 0, "r_ret3");
        drv(1, 1, JUMP, 12'h040, 0, 12'h040, 12'h000, 0, 1, 0, "r_jump040");
        drv(1, 1, RET,  12'h000, 0, 12'h041, 12'h000, 0, 1, 1, "r_unf_ret");
        drv(1, 0, HOLD, 12'h000, 1, 12'h041, 12'h000, 0, 0, 0, "r_clr_nostep");

        // 5: page jumps and wraparound
        drv(0, 1, JUMP,  12'h3F0, 0, 12'h3F0, 12'h000, 0, 0, 0, "jump3f0");
        drv(0, 1, JPAGE, 12'h0A5, 0, 12'h3A5, 12'h000, 0, 0, 0, "jpage");
        drv(0, 1, JPAGE, 12'hF5A, 0, 12'h35A, 12'h000, 0, 0, 0, "jpage_hibits");
        drv(0, 1, JUMP,  12'hFFF, 0, 12'hFFF, 12'h000, 0, 0, 0, "jumpfff");
        drv(0, 1, INC,   12'h000, 0, 12'h000, 12'h000, 0, 0, 0, "inc_wrap");
        drv(0, 1, JUMP,  12'hFFE, 0, 12'hFFE, 12'h000, 0, 0, 0, "jumpffe");
        drv(0, 1, SKIP,  12'h000, 0, 12'h000, 12'h000, 0, 0, 0, "skip_wrap");
        drv(0, 1, INC7,  12'h000, 0, 12'h001, 12'h000, 0, 0, 0, "inc7");
        drv(0, 1, SKIP,  12'h000, 0, 12'h003, 12'h000, 0, 0, 0, "skip");
        drv(0, 1, HOLD,  12'h123, 0, 12'h003, 12'h000, 0, 0, 0, "hold");

        // 6: step gating and set-over-clear
        drv(1, 1, CALL, 12'h100, 0, 12'h100, 12'h042, 1, 0, 0, "g_call1");
        drv(1, 1, CALL, 12'h200, 0, 12'h200, 12'h101, 2, 0, 0, "g_call2");
        drv(1, 1, CALL, 12'h300, 0, 12'h300, 12'h201, 3, 0, 0, "g_call3");
        for (int i = 0; i < 4; i++) begin
            drv(1, 0, CALL, 12'h777, 0, 12'h300, 12'h201, 3, 0, 0, "nostep_call");
        end
        drv(1, 1, CALL, 12'h555, 1, 12'h301, 12'h201, 3, 1, 0, "set_wins");

        rst_all("reset_final");

        // Drain any outstanding expectations within a short bound.
        idle_all();
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) begin
            @(posedge cp2);
        end
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            failures++;
            $display("FAIL %s dut%0d: expectation for cycle %0d never compared", e.nm, e.d, e.cyc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
